board_spi_loader: RTL and testbench
===================================

# board_spi_loader

Upstream pattern-entry stage for the Game of Life board. Receives an SPI mode-0 command stream on spare input pins and converts it into single-cell write transactions on a valid/ready port that the simulation core applies to `board_state`. Also drives a `hold` request so the core stays in its idle action while a frame or its writes are outstanding. Lets a host preload gliders or rows without using the LFSR randomizer.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of each input synchronizer (≥2).
- `LOGW`, 6: log2 board width; x field width.
- `LOGH`, 6: log2 board height; y field width.

- `clk` in 1: system clock (24 MHz pixel/sim clock).
- `reset` in 1: synchronous, active-high reset.
- `spi_sclk` in 1: SPI clock, asynchronous; must be ≤ clk/8.
- `spi_mosi` in 1: SPI data, MSB first, sampled on `spi_sclk` rising edge.
- `spi_cs_n` in 1: frame select, active low.
- `wr_valid` out 1: write transaction pending.
- `wr_ready` in 1: core accepts the write this cycle.
- `wr_addr` out LOGW+LOGH: cell index `{y, x}`.
- `wr_data` out 1: new cell state.
- `hold` out 1: request the core to remain idle.
- `err` out 1: sticky frame error; cleared on next `spi_cs_n` falling edge.

## Operation
- All three SPI inputs pass through SYNC_STAGES flops, then one edge-detect register. `sclk` rising edge shifts `mosi` into an 8-bit shift register; the 8th edge raises `byte_stb` for one cycle.
- `spi_cs_n` high (synchronized) forces the bit counter to 0 and the FSM to IDLE; partial bytes and incomplete commands are discarded with no writes.
- Commands (first byte of frame):
  - 0x10 SET: 2 argument bytes, packed 16 bits `{4'b0, y[5:0], x[5:0]}`; one write, data 1.
  - 0x11 CLR: same format; one write, data 0.
  - 0x20 ROW: 1 byte row y (low LOGH bits), then 8 data bytes; byte k bit 7 → x=8k, bit 0 → x=8k+7; 8 writes per byte.
  - 0x30 CLEAR_ALL: no arguments; writes data 0 to addresses 0..2^(LOGW+LOGH)−1 in order.
  - any other value: `err`←1; the rest of the frame is ignored.
- FSM states: IDLE → CMD on `cs_n` falling; CMD → ARG (SET/CLR/ROW), WIPE (CLEAR_ALL) or DISCARD (unknown) on `byte_stb`; ARG → ISSUE when the argument set completes; ISSUE → ARG (ROW with data bytes remaining) or CMD (frame continues, next byte is a new command) after the last handshake; WIPE → CMD after the final address is accepted; DISCARD → IDLE on `cs_n` high.
- Issue buffer: one byte plus a 3-bit bit pointer. If a `byte_stb` arrives while the buffer still holds unissued bits, the new byte is dropped and `err`←1.
- WIPE and ISSUE run to completion even if `cs_n` rises; the FSM then goes to IDLE.
- `hold` = `cs_n` synchronized low OR `wr_valid` OR FSM in WIPE.
- Reset values: `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `hold`=0, `err`=0, FSM=IDLE, synchronizers cleared to idle (`cs_n`=1, `sclk`=0). Reset mid-transfer aborts all writes immediately.

## Timing
- Input to `byte_stb`: SYNC_STAGES+1 cycles after the 8th `sclk` rising edge reaches the pin.
- `wr_valid` rises the cycle after the `byte_stb` that completes an argument set (SET/CLR/ROW data byte), or the cycle after CMD decodes 0x30.
- Handshake: a transfer occurs when `wr_valid`&`wr_ready`. While `wr_valid`&!`wr_ready`, `wr_addr`/`wr_data` stay stable. The next write presents in the following cycle (1 write/cycle with `wr_ready` tied high).
- ROW byte: 8 writes in 8 cycles minimum; the next byte needs ≥64 clk cycles at max `sclk`, so overflow occurs only if `wr_ready` stalls beyond that.
- CLEAR_ALL at 64×64: ≥4096 cycles; `wr_addr` increments only on an accepted transfer, and the final transfer at address 4095 wraps nothing and ends WIPE.
- `err` sets one cycle after the offending `byte_stb`. A new `cs_n` falling edge and an error in the same cycle: the error wins.

## Configuration
- `BOARD_LOADER_CLEAR_ALL_EN`: defined → 0x30 implemented as above with WIPE state and address counter. Undefined → WIPE logic absent; 0x30 decodes as unknown (`err`←1, frame discarded).

## Test plan
- SET frame 0x10,0x08,0x45 (y=0x21, x=0x05), `wr_ready`=1 → exactly one transfer, `wr_addr`=0x845, `wr_data`=1; `hold` drops after `cs_n` rises.
- ROW frame 0x20,0x03, then data 0x80, then seven 0x00 bytes, with `wr_ready` toggling 1/0 → 64 transfers, addresses 0x0C0..0x0FF in order, data 1 only at 0x0C0; `addr`/`data` stable during stalls.
- Unknown command 0x55 followed by 0x10,0x00,0x01 in the same frame → no transfers, `err`=1 until the next `cs_n` falling edge.
- CLEAR_ALL with `BOARD_LOADER_CLEAR_ALL_EN` defined, `cs_n` raised right after the command byte → 4096 transfers of data 0, addresses 0..4095, `hold` high throughout; with the macro undefined → `err`=1 and zero transfers.
- SET frame truncated after the first argument byte (`cs_n` rises) → no transfer; `err`=0.
- `reset` pulsed during ROW issue with `wr_ready`=0 → next cycle `wr_valid`=0, `hold`=0; a following SET frame executes normally.

Source files
------------

// File: rtl/board_spi_loader_if.sv
// rtl/board_spi_loader_if.sv - single-cell write port between the SPI loader and the board core
// Ports (signals of the interface):
//   wr_valid  master->slave  write transaction pending
//   wr_ready  slave->master  core accepts the write this cycle
//   wr_addr   master->slave  cell index {y, x}, LOGW+LOGH bits
//   wr_data   master->slave  new cell state
interface board_spi_loader_if #(
    parameter int LOGW = 6,
    parameter int LOGH = 6
);
    logic                   wr_valid;
    logic                   wr_ready;
    logic [LOGW+LOGH-1:0]   wr_addr;
    logic                   wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/board_spi_loader.sv
// rtl/board_spi_loader.sv - SPI mode-0 pattern loader issuing single-cell board writes
// Optional feature macro: BOARD_LOADER_CLEAR_ALL_EN (enables the 0x30 CLEAR_ALL wipe).
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   spi_sclk/mosi/cs_n asynchronous SPI inputs (sclk <= clk/8)
//   wr                 write port (master side of board_spi_loader_if)
//   hold               asks the core to stay idle while a frame or writes are outstanding
//   err                sticky frame error, cleared on the next cs_n falling edge
// The SET/CLR argument packing assumes 9 <= LOGW+LOGH <= 16.
module board_spi_loader #(
    parameter int SYNC_STAGES = 2,
    parameter int LOGW        = 6,
    parameter int LOGH        = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    input  logic                 spi_cs_n,
    board_spi_loader_if.master   wr,
    output logic                 hold,
    output logic                 err
);
    localparam int AW = LOGW + LOGH;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ARG, S_ISSUE, S_WIPE, S_DISCARD
    } state_t;

    typedef enum logic [1:0] {C_SET, C_CLR, C_ROW} cmd_t;

    // ---------------- input synchronizers + edge detect ----------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sclk_prev_q, cs_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, mosi_s, cs_s, sclk_rise, cs_fall;
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // ---------------- byte assembly ----------------
    // mosi travels through the same synchronizer depth as sclk, so the value
    // seen alongside the synchronized rising edge is the one at the pin edge.
    logic [6:0] sh_q;
    logic [2:0] bit_cnt_q;
    logic       byte_stb;
    logic [7:0] rx_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q      <= '0;
            bit_cnt_q <= '0;
        end else if (cs_s) begin
            bit_cnt_q <= '0;
        end else if (sclk_rise) begin
            sh_q      <= {sh_q[5:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

    assign byte_stb = sclk_rise & ~cs_s & (bit_cnt_q == 3'd7);
    assign rx_byte  = {sh_q, mosi_s};

    // ---------------- command FSM ----------------
    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [3:0]       arg_cnt_q, arg_cnt_d;   // ROW: 0 = expecting y, n = data byte n-1 next
    logic [AW-9:0]    arg_hi_q, arg_hi_d;     // useful bits of the first SET/CLR argument
    logic [LOGH-1:0]  row_y_q, row_y_d;
    logic [6:0]       buf_q, buf_d;           // ROW bits not yet presented, MSB next
    logic [2:0]       ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             data_q, data_d;
    logic             err_q, err_d;
    logic             set_err;
    logic             xfer;
    logic [2:0]       row_k;

    assign xfer  = valid_q & wr.wr_ready;
    assign row_k = 3'(arg_cnt_q - 4'd1);

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        arg_cnt_d = arg_cnt_q;
        arg_hi_d  = arg_hi_q;
        row_y_d   = row_y_q;
        buf_d     = buf_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        set_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cs_fall) state_d = S_CMD;
            end
            S_CMD: begin
                if (cs_s) begin
                    state_d = S_IDLE;
                end else if (byte_stb) begin
                    arg_cnt_d = '0;
                    case (rx_byte)
                        8'h10: begin cmd_d = C_SET; state_d = S_ARG; end
                        8'h11: begin cmd_d = C_CLR; state_d = S_ARG; end
                        8'h20: begin cmd_d = C_ROW; state_d = S_ARG; end
`ifdef BOARD_LOADER_CLEAR_ALL_EN
                        8'h30: begin
                            state_d = S_WIPE;
                            addr_d  = '0;
                            data_d  = 1'b0;
                            valid_d = 1'b1;
                        end
`endif
                        default: begin
                            set_err = 1'b1;
                            state_d = S_DISCARD;
                        end
                    endcase
                end
            end
            S_ARG: begin
                if (cs_s) begin
                    state_d = S_IDLE;
                end else if (byte_stb) begin
                    if (arg_cnt_q == 4'd0) begin
                        arg_hi_d  = rx_byte[AW-9:0];
                        row_y_d   = rx_byte[LOGH-1:0];
                        arg_cnt_d = 4'd1;
                    end else if (cmd_q == C_ROW) begin
                        addr_d    = {row_y_q, LOGW'({row_k, 3'b000})};
                        data_d    = rx_byte[7];
                        buf_d     = rx_byte[6:0];
                        ptr_d     = '0;
                        valid_d   = 1'b1;
                        arg_cnt_d = arg_cnt_q + 4'd1;
                        state_d   = S_ISSUE;
                    end else begin
                        addr_d  = {arg_hi_q, rx_byte};
                        data_d  = (cmd_q == C_SET);
                        valid_d = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // The single issue buffer is busy: a byte arriving now is lost.
                if (byte_stb) set_err = 1'b1;
                if (xfer) begin
                    if (cmd_q == C_ROW && ptr_q != 3'd7) begin
                        ptr_d  = ptr_q + 3'd1;
                        addr_d = addr_q + AW'(1);
                        data_d = buf_q[6];
                        buf_d  = {buf_q[5:0], 1'b0};
                    end else begin
                        valid_d = 1'b0;
                        if (cs_s)
                            state_d = S_IDLE;
                        else if (cmd_q == C_ROW && arg_cnt_q != 4'd9)
                            state_d = S_ARG;
                        else
                            state_d = S_CMD;
                    end
                end
            end
            S_WIPE: begin
`ifdef BOARD_LOADER_CLEAR_ALL_EN
                if (byte_stb) set_err = 1'b1;
                if (xfer) begin
                    if (addr_q == {AW{1'b1}}) begin
                        valid_d = 1'b0;
                        state_d = cs_s ? S_IDLE : S_CMD;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DISCARD: begin
                if (cs_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new frame clears the sticky error, but an error in the same cycle wins.
        err_d = err_q;
        if (cs_fall) err_d = 1'b0;
        if (set_err) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= C_SET;
            arg_cnt_q <= '0;
            arg_hi_q  <= '0;
            row_y_q   <= '0;
            buf_q     <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            arg_cnt_q <= arg_cnt_d;
            arg_hi_q  <= arg_hi_d;
            row_y_q   <= row_y_d;
            buf_q     <= buf_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign wr.wr_valid = valid_q;
    assign wr.wr_addr  = addr_q;
    assign wr.wr_data  = data_q;
    assign err         = err_q;
    assign hold        = ~cs_s | valid_q | (state_q == S_WIPE);
endmodule

// File: tb/tb_board_spi_loader.sv
// tb/tb_board_spi_loader.sv - self-checking bench for board_spi_loader
module tb_board_spi_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spi_sclk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_cs_n = 1'b1;
    logic hold, err;

    board_spi_loader_if #(.LOGW(6), .LOGH(6)) wr_if ();

    board_spi_loader #(.SYNC_STAGES(2), .LOGW(6), .LOGH(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_cs_n (spi_cs_n),
        .wr       (wr_if),
        .hold     (hold),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int n_xfer = 0;
    int ready_mode = 1;   // 0 low, 1 high, 2 toggling
    logic wipe_chk = 1'b0;

    typedef struct {logic [11:0] addr; logic data;} exp_t;
    exp_t sb[$];
    exp_t e;

    typedef struct {logic [7:0] c; logic [7:0] a0; logic [7:0] a1; logic [11:0] addr; logic data;} vec_t;
    vec_t vt[5];

    logic [7:0] fb[0:15];
    int flen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            wait_clk(8);
            spi_sclk = 1'b1;
            wait_clk(8);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame();
        spi_cs_n = 1'b0;
        wait_clk(8);
        check("hold_in_frame", hold, 1);
        for (int i = 0; i < flen; i++) send_byte(fb[i]);
        wait_clk(8);
        spi_cs_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic drain(input string name, input int bound);
        int c;
        c = 0;
        while (sb.size() != 0 && c < bound) begin
            @(posedge clk);
            c++;
        end
        check({name, "_remaining"}, sb.size(), 0);
        sb.delete();
        wait_clk(20);
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)      wr_if.wr_ready = 1'b0;
        else if (ready_mode == 1) wr_if.wr_ready = 1'b1;
        else                      wr_if.wr_ready = ~wr_if.wr_ready;
    end

    logic stall_seen = 1'b0;
    logic [11:0] stall_addr;
    logic stall_data;

    always @(negedge clk) begin
        if (reset) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen && wr_if.wr_valid) begin
                check("stall_addr", wr_if.wr_addr, stall_addr);
                check("stall_data", wr_if.wr_data, stall_data);
            end
            stall_seen = 1'b0;
            if (wr_if.wr_valid && wr_if.wr_ready) begin
                n_xfer++;
                if (wipe_chk) check("wipe_hold", hold, 1);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got addr 0x%0h data %0b expected none",
                             wr_if.wr_addr, wr_if.wr_data);
                end else begin
                    e = sb.pop_front();
                    check("xfer_addr", wr_if.wr_addr, e.addr);
                    check("xfer_data", wr_if.wr_data, e.data);
                end
            end else if (wr_if.wr_valid) begin
                stall_seen = 1'b1;
                stall_addr = wr_if.wr_addr;
                stall_data = wr_if.wr_data;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        vt[0] = '{c: 8'h10, a0: 8'h08, a1: 8'h45, addr: 12'h845, data: 1'b1};
        vt[1] = '{c: 8'h11, a0: 8'h0F, a1: 8'hFF, addr: 12'hFFF, data: 1'b0};
        vt[2] = '{c: 8'h10, a0: 8'h00, a1: 8'h00, addr: 12'h000, data: 1'b1};
        vt[3] = '{c: 8'h11, a0: 8'h00, a1: 8'h41, addr: 12'h041, data: 1'b0};
        vt[4] = '{c: 8'h10, a0: 8'hF0, a1: 8'h01, addr: 12'h001, data: 1'b1};

        wr_if.wr_ready = 1'b1;
        reset = 1'b1;
        wait_clk(5);
        check("rst_valid", wr_if.wr_valid, 0);
        check("rst_addr", wr_if.wr_addr, 0);
        check("rst_data", wr_if.wr_data, 0);
        check("rst_hold", hold, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        wait_clk(5);

        // unknown command, trailing SET bytes must be ignored
        fb[0] = 8'h55; fb[1] = 8'h10; fb[2] = 8'h00; fb[3] = 8'h01; flen = 4;
        x0 = n_xfer;
        send_frame();
        wait_clk(50);
        check("unk_err", err, 1);
        check("unk_xfers", n_xfer - x0, 0);

        // SET/CLR vector table; first frame also clears the sticky error
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{addr: vt[i].addr, data: vt[i].data});
            fb[0] = vt[i].c; fb[1] = vt[i].a0; fb[2] = vt[i].a1; flen = 3;
            x0 = n_xfer;
            send_frame();
            drain("vec", 200);
            check("vec_xfers", n_xfer - x0, 1);
            check("vec_err", err, 0);
            check("vec_hold_after", hold, 0);
        end

        // ROW with a stalling core
        ready_mode = 2;
        for (int i = 0; i < 64; i++) sb.push_back('{addr: 12'h0C0 + 12'(i), data: (i == 0)});
        fb[0] = 8'h20; fb[1] = 8'h03; fb[2] = 8'h80;
        for (int i = 3; i < 10; i++) fb[i] = 8'h00;
        flen = 10;
        x0 = n_xfer;
        send_frame();
        drain("row", 3000);
        check("row_xfers", n_xfer - x0, 64);
        check("row_err", err, 0);
        ready_mode = 1;
        wait_clk(4);

        // CLEAR_ALL, cs_n raised right after the command byte
        fb[0] = 8'h30; flen = 1;
        x0 = n_xfer;
`ifdef BOARD_LOADER_CLEAR_ALL_EN
        for (int i = 0; i < 4096; i++) sb.push_back('{addr: 12'(i), data: 1'b0});
        wipe_chk = 1'b1;
        send_frame();
        drain("wipe", 10000);
        wipe_chk = 1'b0;
        check("wipe_xfers", n_xfer - x0, 4096);
        check("wipe_err", err, 0);
        check("wipe_hold_after", hold, 0);
`else
        send_frame();
        wait_clk(50);
        check("clr_all_err", err, 1);
        check("clr_all_xfers", n_xfer - x0, 0);
`endif

        // truncated SET
        fb[0] = 8'h10; fb[1] = 8'h08; flen = 2;
        x0 = n_xfer;
        send_frame();
        wait_clk(50);
        check("trunc_xfers", n_xfer - x0, 0);
        check("trunc_err", err, 0);

        // reset while a ROW issue is stalled
        ready_mode = 0;
        fb[0] = 8'h20; fb[1] = 8'h01; fb[2] = 8'hFF; flen = 3;
        x0 = n_xfer;
        send_frame();
        wait_clk(10);
        check("stalled_valid", wr_if.wr_valid, 1);
        check("stalled_hold", hold, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_valid", wr_if.wr_valid, 0);
        check("rst_mid_hold", hold, 0);
        wait_clk(2);
        reset = 1'b0;
        ready_mode = 1;
        wait_clk(5);
        check("rst_mid_xfers", n_xfer - x0, 0);

        sb.push_back('{addr: 12'hFC0, data: 1'b1});
        fb[0] = 8'h10; fb[1] = 8'h3F; fb[2] = 8'hC0; flen = 3;
        x0 = n_xfer;
        send_frame();
        drain("post_rst", 200);
        check("post_rst_xfers", n_xfer - x0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
